// File: rtl/posit_pkg.sv
// Shared definitions for the posit normaliser: FSM state encoding, default
// field widths and the saturating signed scale adder.
package posit_pkg;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    localparam int POSIT_MANT_W   = 64;
    localparam int POSIT_SCALE_W  = 10;
    localparam int POSIT_ES       = 3;
    localparam int POSIT_MAX_STEP = 4;

    typedef struct packed {
        logic ovf;
        int   val;
    } sat_res_t;

    // Adds two signed values and clamps the result to a w-bit two's complement range.
    function automatic sat_res_t sat_add(input int a, input int b, input int w);
        sat_res_t r;
        int lo;
        int hi;
        int s;
        lo    = -(1 <<< (w - 1));
        hi    = (1 <<< (w - 1)) - 1;
        s     = a + b;
        r.ovf = 1'b0;
        r.val = s;
        if (s > hi) begin
            r.val = hi;
            r.ovf = 1'b1;
        end else if (s < lo) begin
            r.val = lo;
            r.ovf = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/posit_lzc.sv
// Combinational leading-zero counter; an all-zero input returns MANT_W.
module posit_lzc #(
    parameter int MANT_W = 64,
    parameter int CNT_W  = $clog2(MANT_W) + 1
) (
    input  logic [MANT_W-1:0] data_i,
    output logic [CNT_W-1:0]  count_o
);

    // Ascending scan: the highest set bit is the last one to write the count.
    always_comb begin
        count_o = CNT_W'(MANT_W);
        for (int i = 0; i < MANT_W; i++) begin
            if (data_i[i]) begin
                count_o = CNT_W'(MANT_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/posit_norm_adjust_p.sv
// Posit multiplier normaliser: shifts the mantissa product until its top two
// bits are 01, tracking scale (saturating), shift count and right-shift sticky.
module posit_norm_adjust_p
    import posit_pkg::*;
#(
    parameter int MANT_W   = POSIT_MANT_W,
    parameter int SCALE_W  = POSIT_SCALE_W,
    parameter int ES       = POSIT_ES,
    parameter int MAX_STEP = POSIT_MAX_STEP
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SCALE_W-1:0]         scale_in,
    input  logic [MANT_W-1:0]          mant_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SCALE_W-1:0]         scale_out,
    output logic [MANT_W-1:0]          mant_out,
    output logic [$clog2(MANT_W):0]    shift_amt,
    output logic                       sticky_out,
    output logic                       zero_out,
    output logic                       ovf_out,
    output logic [ES-1:0]              adj_exp,
    output logic [SCALE_W-ES-2:0]      adj_regime,
    output logic                       exp_sign
);

    localparam int CW = $clog2(MANT_W) + 1;

    logic [1:0]          state_q, state_d;
    logic [MANT_W-1:0]   work_q, work_d;
    logic [SCALE_W-1:0]  wscale_q, wscale_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                sticky_q, sticky_d;
    logic                ovf_q, ovf_d;

    logic                out_valid_q;
    logic [SCALE_W-1:0]  scale_out_q;
    logic [MANT_W-1:0]   mant_out_q;
    logic [CW-1:0]       shift_amt_q;
    logic                sticky_out_q;
    logic                zero_out_q;
    logic                ovf_out_q;

    logic [CW-1:0]       lz;
    logic [CW-1:0]       k;
    logic [CW-1:0]       step;
    logic [1:0]          top;
    sat_res_t            sat;

    assign top = work_q[MANT_W-1:MANT_W-2];

    posit_lzc #(
        .MANT_W (MANT_W),
        .CNT_W  (CW)
    ) u_lzc (
        .data_i  (work_q),
        .count_o (lz)
    );

    // One normalisation step; only committed while in SHIFT with top != 01.
    always_comb begin
        k        = lz - CW'(1);
        step     = (k > CW'(MAX_STEP)) ? CW'(MAX_STEP) : k;
        work_d   = work_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (work_q[MANT_W-1]) begin
            work_d   = work_q >> 1;
            sticky_d = sticky_q | work_q[0];
            cnt_d    = cnt_q + CW'(1);
            sat      = sat_add(int'($signed(wscale_q)), 1, SCALE_W);
        end else begin
            work_d   = work_q << step;
            cnt_d    = cnt_q + step;
            sat      = sat_add(int'($signed(wscale_q)), -int'(step), SCALE_W);
        end
        wscale_d = SCALE_W'(sat.val);
        ovf_d    = ovf_q | sat.ovf;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = (mant_in == '0) ? ST_HOLD : ST_SHIFT;
            ST_SHIFT: if (top == 2'b01) state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_q       <= '0;
            wscale_q     <= '0;
            cnt_q        <= '0;
            sticky_q     <= 1'b0;
            ovf_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            scale_out_q  <= '0;
            mant_out_q   <= '0;
            shift_amt_q  <= '0;
            sticky_out_q <= 1'b0;
            zero_out_q   <= 1'b0;
            ovf_out_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q   <= mant_in;
                        wscale_q <= scale_in;
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        if (mant_in == '0) begin
                            out_valid_q  <= 1'b1;
                            zero_out_q   <= 1'b1;
                            scale_out_q  <= '0;
                            mant_out_q   <= '0;
                            shift_amt_q  <= '0;
                            sticky_out_q <= 1'b0;
                            ovf_out_q    <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (top == 2'b01) begin
                        out_valid_q  <= 1'b1;
                        zero_out_q   <= 1'b0;
                        scale_out_q  <= wscale_q;
                        mant_out_q   <= work_q;
                        shift_amt_q  <= cnt_q;
                        sticky_out_q <= sticky_q;
                        ovf_out_q    <= ovf_q;
                    end else begin
                        work_q   <= work_d;
                        wscale_q <= wscale_d;
                        cnt_q    <= cnt_d;
                        sticky_q <= sticky_d;
                        ovf_q    <= ovf_d;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign scale_out  = scale_out_q;
    assign mant_out   = mant_out_q;
    assign shift_amt  = shift_amt_q;
    assign sticky_out = sticky_out_q;
    assign zero_out   = zero_out_q;
    assign ovf_out    = ovf_out_q;
    assign adj_exp    = scale_out_q[ES-1:0];
    assign adj_regime = scale_out_q[SCALE_W-2:ES];
    assign exp_sign   = scale_out_q[SCALE_W-1];

endmodule
